// File: rtl/syn_lb_reg_pkg.sv
// Shared register map, reset values and IRQ width for the local-bus register slave.
package syn_lb_reg_pkg;

    localparam int IRQ_W = 8;

    typedef enum logic [3:0] {
        OFF_CTRL     = 4'h0,
        OFF_STATUS   = 4'h1,
        OFF_SCRATCH  = 4'h2,
        OFF_IRQ_STAT = 4'h3,
        OFF_IRQ_MASK = 4'h4,
        OFF_EVT_CNT  = 4'h5
    } reg_off_e;

    localparam logic [31:0]      CTRL_RST     = 32'h0000_0000;
    localparam logic [31:0]      SCRATCH_RST  = 32'h0000_0000;
    localparam logic [31:0]      EVT_CNT_RST  = 32'h0000_0000;
    localparam logic [IRQ_W-1:0] IRQ_STAT_RST = '0;
    localparam logic [IRQ_W-1:0] IRQ_MASK_RST = '0;

endpackage

// File: rtl/syn_lb_intf.sv
// Local-bus interface: master issues rd_en/wr_en with addr/wr_data, slave answers with valids.
interface syn_lb_intf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) ();
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport slave (
        input  rd_en, wr_en, addr, wr_data,
        output wr_valid, rd_valid, rd_data
    );

    modport master (
        output rd_en, wr_en, addr, wr_data,
        input  wr_valid, rd_valid, rd_data
    );
endinterface

// File: rtl/syn_sat_cntr.sv
// Saturating event counter with synchronous clear; an increment in the clear cycle leaves 1.
module syn_sat_cntr
    import syn_lb_reg_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_ir,
    input  logic         rst_il,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (inc) begin
            if (clr)
                cnt_next = W'(1);
            else if (!(&cnt_reg))
                cnt_next = cnt_reg + W'(1);
        end else if (clr) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk_ir or posedge rst_il) begin
        if (rst_il)
            cnt_reg <= W'(EVT_CNT_RST);
        else
            cnt_reg <= cnt_next;
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/syn_lb_reg_slave.sv
// Local-bus register slave: CTRL/STATUS/SCRATCH/IRQ_STAT/IRQ_MASK/EVT_CNT behind one block code.
module syn_lb_reg_slave
    import syn_lb_reg_pkg::*;
#(
    parameter int         DATA_W   = 32,
    parameter int         ADDR_W   = 12,
    parameter logic [7:0] BLK_CODE = 8'h01
) (
    input  logic              clk_ir,
    input  logic              rst_il,
    syn_lb_intf.slave         lb,
    input  logic [DATA_W-1:0] status_i,
    input  logic [IRQ_W-1:0]  irq_evt_i,
    input  logic              cnt_evt_i,
    output logic [DATA_W-1:0] ctrl_o,
    output logic              irq_o
);

    localparam logic [ADDR_W-5:0] BLK_SEL = (ADDR_W-4)'(BLK_CODE);

    logic              blk_sel;
    logic [3:0]        off;
    logic              wr_acc;
    logic              rd_acc;
    logic              wr_ctrl;
    logic              wr_scratch;
    logic              wr_irq_stat;
    logic              wr_irq_mask;
    logic              rd_evt_cnt;

    logic [DATA_W-1:0] ctrl_reg;
    logic [DATA_W-1:0] scratch_reg;
    logic [IRQ_W-1:0]  irq_stat_reg;
    logic [IRQ_W-1:0]  irq_stat_next;
    logic [IRQ_W-1:0]  irq_mask_reg;
    logic              irq_reg;
    logic              wr_valid_reg;
    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] evt_cnt;

    assign blk_sel = (lb.addr[ADDR_W-1:4] == BLK_SEL);
    assign off     = lb.addr[3:0];
    assign wr_acc  = blk_sel && lb.wr_en;
    // A simultaneous read and write is a write only, so reads need wr_en low.
    assign rd_acc  = blk_sel && lb.rd_en && !lb.wr_en;

    assign wr_ctrl     = wr_acc && (off == OFF_CTRL);
    assign wr_scratch  = wr_acc && (off == OFF_SCRATCH);
    assign wr_irq_stat = wr_acc && (off == OFF_IRQ_STAT);
    assign wr_irq_mask = wr_acc && (off == OFF_IRQ_MASK);
    assign rd_evt_cnt  = rd_acc && (off == OFF_EVT_CNT);

    // New events win over a same-cycle W1C of the same bit.
    genvar gi;
    generate
        for (gi = 0; gi < IRQ_W; gi++) begin : g_irq_stat
            assign irq_stat_next[gi] = irq_evt_i[gi] |
                                       (irq_stat_reg[gi] & ~(wr_irq_stat & lb.wr_data[gi]));
        end
    endgenerate

    syn_sat_cntr #(
        .W (DATA_W)
    ) u_evt_cnt (
        .clk_ir (clk_ir),
        .rst_il (rst_il),
        .inc    (cnt_evt_i),
        .clr    (rd_evt_cnt),
        .cnt    (evt_cnt)
    );

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CTRL:     rd_mux = ctrl_reg;
            OFF_STATUS:   rd_mux = status_i;
            OFF_SCRATCH:  rd_mux = scratch_reg;
            OFF_IRQ_STAT: rd_mux = DATA_W'(irq_stat_reg);
            OFF_IRQ_MASK: rd_mux = DATA_W'(irq_mask_reg);
            OFF_EVT_CNT:  rd_mux = evt_cnt;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_ir or posedge rst_il) begin
        if (rst_il) begin
            ctrl_reg     <= DATA_W'(CTRL_RST);
            scratch_reg  <= DATA_W'(SCRATCH_RST);
            irq_stat_reg <= IRQ_STAT_RST;
            irq_mask_reg <= IRQ_MASK_RST;
            irq_reg      <= 1'b0;
            wr_valid_reg <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            if (wr_ctrl)
                ctrl_reg <= lb.wr_data;
            if (wr_scratch)
                scratch_reg <= lb.wr_data;
            if (wr_irq_mask)
                irq_mask_reg <= lb.wr_data[IRQ_W-1:0];
            irq_stat_reg <= irq_stat_next;
            irq_reg      <= |(irq_stat_reg & irq_mask_reg);
            wr_valid_reg <= wr_acc;
            rd_valid_reg <= rd_acc;
            rd_data_reg  <= rd_acc ? rd_mux : '0;
        end
    end

    assign lb.wr_valid = wr_valid_reg;
    assign lb.rd_valid = rd_valid_reg;
    assign lb.rd_data  = rd_data_reg;
    assign ctrl_o      = ctrl_reg;
    assign irq_o       = irq_reg;

endmodule
